// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores against a registered-input word memory.
module load_store_unit #(
    parameter int MEM_SIZE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_w_enable,
    output logic        mem_r_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, WRW, RESP} state_t;
    state_t      state, state_nx;
    logic        we, err, acc_err;
    logic [2:0]  funct3;
    logic [31:0] addr, wword, rdata, ld_val, lane_mask, lane_data, merged;
    logic [4:0]  sh;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    always_comb begin
        acc_err = (req_funct3 inside {3'b011, 3'b110, 3'b111})
               || (req_we && req_funct3[2])
               || (req_funct3[1:0] == 2'b01 && req_addr[0])
               || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
               || ({req_addr[31:2], 2'b00} + 32'd3 >= 32'(MEM_SIZE));
        sh = {addr[1:0], 3'b000};
        ld_b = mem_data_out[sh +: 8];
        ld_h = mem_data_out[{addr[1], 4'b0000} +: 16];
        ld_val = funct3[1] ? mem_data_out
               : funct3[0] ? {{16{ld_h[15] & ~funct3[2]}}, ld_h}
               : {{24{ld_b[7] & ~funct3[2]}}, ld_b};
        // sub-word store: splice the new lanes into the word just read back
        lane_mask = (funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        lane_data = (funct3[0] ? {16'b0, wword[15:0]} : {24'b0, wword[7:0]}) << sh;
        merged = (mem_data_out & ~lane_mask) | lane_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        req_ready = 1'b0;
        mem_r_enable = 1'b0;
        mem_w_enable = 1'b0;
        mem_addr = {addr[31:2], 2'b00};
        mem_data_in = 32'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_addr = 32'b0;
                if (req_valid)
                    state_nx = acc_err ? RESP : (req_we && req_funct3 == 3'b010) ? WR : RD;
            end
            RD: begin
                mem_r_enable = 1'b1;
                state_nx = RDW;
            end
            RDW: state_nx = we ? WR : RESP;
            WR: begin
                mem_w_enable = 1'b1;
                mem_data_in = wword;
                state_nx = WRW;
            end
            WRW: state_nx = RESP;
            RESP: state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we <= 1'b0;
            err <= 1'b0;
            funct3 <= 3'b0;
            addr <= 32'b0;
            wword <= 32'b0;
            rdata <= 32'b0;
        end else if (state == IDLE && req_valid) begin
            we <= req_we;
            err <= acc_err;
            funct3 <= req_funct3;
            addr <= req_addr;
            wword <= req_wdata;
            rdata <= 32'b0;
        end else if (state == RDW) begin
            if (we)
                wword <= merged;
            else
                rdata <= ld_val;
        end
    end
    assign resp_valid = (state == RESP);
    assign resp_err = resp_valid & err;
    assign resp_rdata = resp_valid ? rdata : 32'b0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed accesses against a byte-array reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0, mem_clr = 1'b1;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        req_ready, resp_valid, resp_err, mem_w_enable, mem_r_enable;
    logic [31:0] resp_rdata, mem_addr, mem_data_in, mem_data_out;
    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic        r_we;
    logic [31:0] r_addr, r_din, last_rdata;
    int          n_vec = 0, n_err = 0, ren_cnt = 0, wen_cnt = 0;

    load_store_unit #(.MEM_SIZE(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // downstream memory: inputs registered, write lands one edge later
    always @(posedge clk) begin
        if (mem_clr)
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        else if (r_we)
            for (int i = 0; i < 4; i++) mem[r_addr[7:0] + 8'(i)] <= r_din[8*i +: 8];
        r_we <= mem_w_enable;
        r_addr <= mem_addr;
        r_din <= mem_data_in;
        if (mem_r_enable) ren_cnt <= ren_cnt + 1;
        if (mem_w_enable) wen_cnt <= wen_cnt + 1;
    end
    assign mem_data_out = {mem[r_addr[7:0] + 8'd3], mem[r_addr[7:0] + 8'd2],
                           mem[r_addr[7:0] + 8'd1], mem[r_addr[7:0]]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        return (f3 inside {3'b011, 3'b110, 3'b111}) || (we && f3[2]) ||
               (a % 32'(sz) != 0) || ((longint'(a) / 4) * 4 + 3 >= 256);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        logic [31:0] v = 32'b0;
        for (int i = 0; i < sz; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
    endtask

    // one access; hold > 0 keeps resp_ready low that many cycles while a stray store is offered
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic        e, got_err;
        logic [31:0] exp_rd, got_rd;
        int          exp_lat, lat, r0, w0;
        e = ref_err(we, f3, a);
        exp_rd = (e || we) ? 32'b0 : ref_load(f3, a);
        exp_lat = e ? 1 : (!we || f3 == 3'b010) ? 3 : 5;
        @(negedge clk);
        chk({tag, "_rdy"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r0 = ren_cnt;
        w0 = wen_cnt;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk({tag, "_lat"}, lat, exp_lat);
        got_rd = resp_rdata;
        got_err = resp_err;
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_err"}, got_err, e);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 0; req_wdata = 32'h5A5A_5A5A;
            @(negedge clk);
            chk({tag, "_hold_valid"}, resp_valid, 1);
            chk({tag, "_hold_rdata"}, resp_rdata, got_rd);
            chk({tag, "_hold_rdy"}, req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_ren"}, ren_cnt - r0, (!e && (!we || f3 != 3'b010)) ? 1 : 0);
        chk({tag, "_wen"}, wen_cnt - w0, (!e && we) ? 1 : 0);
        if (!e && we) ref_store(f3, a, wd);
        last_rdata = got_rd;
    endtask

    initial begin
        logic [31:0] a;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_mem", {mem_w_enable, mem_r_enable, 30'b0}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_data_in, 0);
        rst = 1'b0;
        mem_clr = 1'b0;

        xact("sw0", 1, 3'b010, 0, 32'hF000_0080, 0);
        xact("lb0", 0, 3'b000, 0, 0, 0);
        chk("lb0_val", last_rdata, 32'hFFFF_FF80);
        xact("lbu0", 0, 3'b100, 0, 0, 0);
        chk("lbu0_val", last_rdata, 32'h0000_0080);
        xact("lw0", 0, 3'b010, 0, 0, 0);
        chk("lw0_val", last_rdata, 32'hF000_0080);

        xact("sw4", 1, 3'b010, 4, 32'h1122_3344, 0);
        xact("sb5", 1, 3'b000, 5, 32'h0000_00AB, 0);
        xact("lw4", 0, 3'b010, 4, 0, 0);
        chk("lw4_val", last_rdata, 32'h1122_AB44);

        xact("lh3", 0, 3'b001, 3, 0, 0);
        xact("lw252", 0, 3'b010, 252, 0, 0);
        xact("lw256", 0, 3'b010, 256, 0, 0);
        xact("bp", 0, 3'b010, 4, 0, 4);
        xact("bp_chk", 0, 3'b010, 0, 0, 0);
        chk("bp_mem0", last_rdata, 32'hF000_0080);

        xact("sw8", 1, 3'b010, 8, 32'hDEAD_BEEF, 0);
        xact("lw8", 0, 3'b010, 8, 0, 0);
        chk("lw8_val", last_rdata, 32'hDEAD_BEEF);

        // abandon a load in RDW
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdw_rst_ready", req_ready, 1);
        chk("rdw_rst_valid", resp_valid, 0);
        chk("rdw_rst_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rdw_rst_idle", resp_valid, 0);
        xact("after_rst", 0, 3'b010, 8, 0, 0);
        chk("after_rst_val", last_rdata, 32'hDEAD_BEEF);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 263));
            xact("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                 ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
